// File: rtl/and_result_skid_buf.sv
// and_result_skid_buf: 2-entry valid/ready skid buffer for the AND-stage result word
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_c upstream side;
// out_valid/out_ready/out_c/out_zero downstream side.
// Optional RESULT_STATS_EN adds stats_clr, xfer_cnt, zero_cnt.
package my_pkg;
  localparam int N = 8;
endpackage

module and_result_skid_buf
  import my_pkg::*;
#(
  parameter int W = N
`ifdef RESULT_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_c,
  output logic         out_zero
`ifdef RESULT_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] zero_cnt
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q, state_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic zero_q, zero_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic in_fire, out_fire;
  assign in_fire = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    case (state_q)
      EMPTY: if (in_fire) begin
        state_d = ONE;
        main_d = in_c;
      end
      ONE: if (in_fire && out_fire) main_d = in_c;
      else if (in_fire) begin
        state_d = FULL;
        skid_d = in_c;
      end
      else if (out_fire) state_d = EMPTY;
      FULL: if (out_fire) begin
        state_d = ONE;
        main_d = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    // handshake outputs are registered from the next state so neither side sees a combinational path
    in_ready_d = state_d != FULL;
    out_valid_d = state_d != EMPTY;
    zero_d = ~|main_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      zero_q <= 1'b1;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
      zero_q <= zero_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_c = main_q;
  assign out_zero = zero_q;
`ifdef RESULT_STATS_EN
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d, zero_cnt_q, zero_cnt_d;
  // counters stick at all-ones; clear wins over a same-cycle increment
  always_comb begin
    xfer_cnt_d = stats_clr ? '0 : (out_fire && xfer_cnt_q != '1) ? xfer_cnt_q + 1'b1 : xfer_cnt_q;
    zero_cnt_d = stats_clr ? '0 : (out_fire && zero_q && zero_cnt_q != '1) ? zero_cnt_q + 1'b1 : zero_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= '0;
      zero_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end
  assign xfer_cnt = xfer_cnt_q;
  assign zero_cnt = zero_cnt_q;
`endif
endmodule
